// File: rtl/ws2812b_pkg.sv
// Shared WS2812B timing constants (64 MHz clock) and receiver state encoding.
`timescale 1ns/1ps
package ws2812b_pkg;

  localparam int T0H            = 26;
  localparam int T1H            = 51;
  localparam int T_BIT          = 80;
  localparam int T_RESET        = 3200;
  localparam int BITS_PER_PIXEL = 24;

  typedef enum logic [1:0] {
    GAP,
    IDLE,
    HIGH,
    LOW
  } rx_state_t;

endpackage

// File: rtl/ws2812b_rx_sync.sv
// Two-flop synchronizer for the serial line with a delayed copy for edge strobes.
`timescale 1ns/1ps
module ws2812b_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_din,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_din;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Strobes are combinational on stage 2 so the consumer registers them one edge later.
  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;
  assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B NRZ receiver: pulse-width decode into GRB pixels, gap detection and
// optional single-LED emulation that forwards everything after the first pixel.
`timescale 1ns/1ps
module ws2812b_rx #(
  parameter int T_MIN_HIGH   = 8,
  parameter int T_BIT_THRESH = 38,
  parameter int T_MAX_HIGH   = 80,
  parameter int T_RESET      = 3200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  input  logic        passthru_en,
  input  logic        err_clr,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic [7:0]  pixel_index,
  output logic        frame_end,
  output logic        busy,
  output logic        err_bit,
  output logic        err_partial,
  output logic        dout
);

  import ws2812b_pkg::*;

  localparam int CW = $clog2(T_RESET + 1);
  localparam logic [CW-1:0] C_MIN_HIGH    = CW'(T_MIN_HIGH);
  localparam logic [CW-1:0] C_BIT_THRESH  = CW'(T_BIT_THRESH);
  localparam logic [CW-1:0] C_MAX_HIGH_M1 = CW'(T_MAX_HIGH - 1);
  localparam logic [CW-1:0] C_RESET       = CW'(T_RESET);
  localparam logic [CW-1:0] C_RESET_M1    = CW'(T_RESET - 1);
  localparam logic [4:0]    C_LAST_BIT    = 5'(BITS_PER_PIXEL - 1);

  logic w_level;
  logic w_rise;
  logic w_fall;

  ws2812b_rx_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_din   (din),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  rx_state_t                   r_state;
  logic [CW-1:0]               r_cnt;
  logic [4:0]                  r_bitcnt;
  logic [7:0]                  r_pixcnt;
  logic [BITS_PER_PIXEL-1:0]   r_shift;
  logic [23:0]                 r_pixel_data;
  logic                        r_pixel_valid;
  logic [7:0]                  r_pixel_index;
  logic                        r_frame_end;
  logic                        r_err_bit;
  logic                        r_err_partial;
  logic                        r_own_done;
  logic                        r_pt;

  rx_state_t                   w_state_next;
  logic [CW-1:0]               w_cnt_next;
  logic [4:0]                  w_bitcnt_next;
  logic [7:0]                  w_pixcnt_next;
  logic [BITS_PER_PIXEL-1:0]   w_shift_next;
  logic [23:0]                 w_data_next;
  logic                        w_valid_next;
  logic [7:0]                  w_index_next;
  logic                        w_fe_next;
  logic                        w_set_bit;
  logic                        w_set_partial;
  logic                        w_own_next;
  logic                        w_pt_next;

  logic                        w_bit;
  logic [CW-1:0]               w_cnt_inc;
  logic [BITS_PER_PIXEL-1:0]   w_shifted;

  assign w_bit     = (r_cnt >= C_BIT_THRESH);
  assign w_cnt_inc = (r_cnt >= C_RESET) ? r_cnt : r_cnt + CW'(1);
  assign w_shifted = {r_shift[BITS_PER_PIXEL-2:0], w_bit};

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_bitcnt_next = r_bitcnt;
    w_pixcnt_next = r_pixcnt;
    w_shift_next  = r_shift;
    w_data_next   = r_pixel_data;
    w_valid_next  = 1'b0;
    w_index_next  = r_pixel_index;
    w_fe_next     = 1'b0;
    w_set_bit     = 1'b0;
    w_set_partial = 1'b0;
    w_own_next    = r_own_done;
    w_pt_next     = r_pt;

    case (r_state)
      GAP: begin
        // Resync: only an unbroken low of T_RESET cycles re-arms the decoder.
        if (w_level) begin
          w_cnt_next = '0;
        end else if (r_cnt >= C_RESET_M1) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      IDLE: begin
        if (w_rise) begin
          w_state_next  = HIGH;
          w_cnt_next    = '0;
          w_bitcnt_next = '0;
          w_pixcnt_next = '0;
          w_pt_next     = passthru_en;
          w_own_next    = 1'b0;
        end
      end

      HIGH: begin
        if (w_fall) begin
          if (r_cnt < C_MIN_HIGH) begin
            w_set_bit    = 1'b1;
            w_state_next = GAP;
            w_cnt_next   = '0;
            w_own_next   = 1'b0;
          end else begin
            w_shift_next = w_shifted;
            w_state_next = LOW;
            w_cnt_next   = '0;
            if (r_bitcnt == C_LAST_BIT) begin
              w_bitcnt_next = '0;
              w_data_next   = w_shifted;
              w_valid_next  = !r_pt || (r_pixcnt == 8'd0);
              w_index_next  = r_pixcnt;
              if (r_pixcnt != 8'hFF) begin
                w_pixcnt_next = r_pixcnt + 8'd1;
              end
              if (r_pt) begin
                w_own_next = 1'b1;
              end
            end else begin
              w_bitcnt_next = r_bitcnt + 5'd1;
            end
          end
        end else if (r_cnt >= C_MAX_HIGH_M1) begin
          w_set_bit    = 1'b1;
          w_state_next = GAP;
          w_cnt_next   = '0;
          w_own_next   = 1'b0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      LOW: begin
        if (w_rise) begin
          w_state_next = HIGH;
          w_cnt_next   = '0;
        end else if (r_cnt >= C_RESET_M1) begin
          w_fe_next     = 1'b1;
          w_set_partial = (r_bitcnt != 5'd0);
          w_state_next  = IDLE;
          w_own_next    = 1'b0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      default: begin
        w_state_next = GAP;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= GAP;
      r_cnt         <= '0;
      r_bitcnt      <= '0;
      r_pixcnt      <= '0;
      r_shift       <= '0;
      r_pixel_data  <= '0;
      r_pixel_valid <= 1'b0;
      r_pixel_index <= '0;
      r_frame_end   <= 1'b0;
      r_err_bit     <= 1'b0;
      r_err_partial <= 1'b0;
      r_own_done    <= 1'b0;
      r_pt          <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_bitcnt      <= w_bitcnt_next;
      r_pixcnt      <= w_pixcnt_next;
      r_shift       <= w_shift_next;
      r_pixel_data  <= w_data_next;
      r_pixel_valid <= w_valid_next;
      r_pixel_index <= w_index_next;
      r_frame_end   <= w_fe_next;
      // A set in the same cycle as err_clr wins.
      r_err_bit     <= w_set_bit | (r_err_bit & ~err_clr);
      r_err_partial <= w_set_partial | (r_err_partial & ~err_clr);
      r_own_done    <= w_own_next;
      r_pt          <= w_pt_next;
    end
  end

  assign pixel_data  = r_pixel_data;
  assign pixel_valid = r_pixel_valid;
  assign pixel_index = r_pixel_index;
  assign frame_end   = r_frame_end;
  assign busy        = (r_state == HIGH) || (r_state == LOW);
  assign err_bit     = r_err_bit;
  assign err_partial = r_err_partial;
  assign dout        = r_own_done & w_level;

endmodule

// File: tb/tb_ws2812b_rx.sv
// Directed bench for ws2812b_rx: decode, gaps, width errors, reset abort, pass-through.
`timescale 1ns/1ps
module tb_ws2812b_rx;
  import ws2812b_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        passthru_en = 1'b0;
  logic        err_clr = 1'b0;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [7:0]  pixel_index;
  logic        frame_end;
  logic        busy;
  logic        err_bit;
  logic        err_partial;
  logic        dout;

  ws2812b_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .passthru_en (passthru_en),
    .err_clr     (err_clr),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_index (pixel_index),
    .frame_end   (frame_end),
    .busy        (busy),
    .err_bit     (err_bit),
    .err_partial (err_partial),
    .dout        (dout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Event recorder: pixel strobes, frame ends, and dout against din delayed two cycles.
  logic [23:0] pv_data [32];
  logic [7:0]  pv_idx  [32];
  int   pv_cnt = 0;
  int   fe_cnt = 0;
  int   dout_mis = 0;
  int   dout_rises = 0;
  logic din_h1 = 1'b0;
  logic din_h2 = 1'b0;
  logic dout_q = 1'b0;
  logic dout_mode = 1'b0;

  always @(negedge clk) begin
    if (pixel_valid === 1'b1) begin
      pv_data[pv_cnt % 32] <= pixel_data;
      pv_idx[pv_cnt % 32]  <= pixel_index;
      pv_cnt <= pv_cnt + 1;
    end
    if (frame_end === 1'b1) fe_cnt <= fe_cnt + 1;
    if (dout !== (dout_mode ? din_h2 : 1'b0)) dout_mis <= dout_mis + 1;
    din_h1 <= din;
    din_h2 <= din_h1;
    dout_q <= dout;
    if (dout === 1'b1 && dout_q === 1'b0) dout_rises <= dout_rises + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int hi;
    hi = b ? T1H : T0H;
    din = 1'b1;
    wait_cyc(hi);
    din = 1'b0;
    wait_cyc(T_BIT - hi);
  endtask

  task automatic send_bits(input logic [23:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic gap();
    din = 1'b0;
    wait_cyc(T_RESET + 10);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
    wait_cyc(2);
  endtask

  int pv0, fe0, mis0, rise0;

  initial begin
    // Reset state
    wait_cyc(5);
    check("rst_data", 32'(pixel_data), 32'h0);
    check("rst_valid", 32'(pixel_valid), 32'h0);
    check("rst_index", 32'(pixel_index), 32'h0);
    check("rst_fe", 32'(frame_end), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_errs", 32'({err_bit, err_partial}), 32'h0);
    check("rst_dout", 32'(dout), 32'h0);
    rst_n = 1'b1;
    gap();

    // Single pixel after startup gap
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_bits(24'h123456, 24);
    gap();
    check("p1_count", 32'(pv_cnt - pv0), 32'd1);
    check("p1_data", 32'(pv_data[pv0 % 32]), 32'h123456);
    check("p1_index", 32'(pv_idx[pv0 % 32]), 32'd0);
    check("p1_fe", 32'(fe_cnt - fe0), 32'd1);
    check("p1_errs", 32'({err_bit, err_partial}), 32'h0);

    // Three-pixel frame
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_bits(24'hFF0000, 24);
    check("mp_busy0", 32'(busy), 32'h1);
    send_bits(24'h00FF00, 24);
    check("mp_busy1", 32'(busy), 32'h1);
    send_bits(24'h0000FF, 24);
    check("mp_busy2", 32'(busy), 32'h1);
    gap();
    check("mp_count", 32'(pv_cnt - pv0), 32'd3);
    check("mp_data0", 32'(pv_data[pv0 % 32]), 32'hFF0000);
    check("mp_data1", 32'(pv_data[(pv0 + 1) % 32]), 32'h00FF00);
    check("mp_data2", 32'(pv_data[(pv0 + 2) % 32]), 32'h0000FF);
    check("mp_idx0", 32'(pv_idx[pv0 % 32]), 32'd0);
    check("mp_idx1", 32'(pv_idx[(pv0 + 1) % 32]), 32'd1);
    check("mp_idx2", 32'(pv_idx[(pv0 + 2) % 32]), 32'd2);
    check("mp_fe", 32'(fe_cnt - fe0), 32'd1);
    check("mp_busy_end", 32'(busy), 32'h0);

    // Partial frame: 12 bits then gap
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_bits(24'h000ABC, 12);
    gap();
    check("part_count", 32'(pv_cnt - pv0), 32'd0);
    check("part_fe", 32'(fe_cnt - fe0), 32'd1);
    check("part_err", 32'(err_partial), 32'h1);
    check("part_errbit", 32'(err_bit), 32'h0);
    pulse_clr();
    check("part_clr", 32'(err_partial), 32'h0);

    // Glitch: 4-cycle high, then bits without a full gap are ignored
    pv0 = pv_cnt; fe0 = fe_cnt;
    din = 1'b1; wait_cyc(4);
    din = 1'b0; wait_cyc(100);
    check("glitch_err", 32'(err_bit), 32'h1);
    check("glitch_busy", 32'(busy), 32'h0);
    send_bits(24'h111111, 24);
    gap();
    check("glitch_count", 32'(pv_cnt - pv0), 32'd0);
    check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);
    pulse_clr();
    check("glitch_clr", 32'(err_bit), 32'h0);

    // Over-long 100-cycle high
    pv0 = pv_cnt; fe0 = fe_cnt;
    din = 1'b1; wait_cyc(100);
    gap();
    check("long_err", 32'(err_bit), 32'h1);
    check("long_count", 32'(pv_cnt - pv0), 32'd0);
    check("long_fe", 32'(fe_cnt - fe0), 32'd0);

    // Reset release with line high; bits without a gap give nothing
    rst_n = 1'b0; din = 1'b1;
    wait_cyc(5);
    check("rst2_errbit", 32'(err_bit), 32'h0);
    rst_n = 1'b1;
    wait_cyc(20);
    pv0 = pv_cnt; fe0 = fe_cnt;
    din = 1'b0; wait_cyc(20);
    send_bits(24'h5A5A5A, 24);
    gap();
    check("startup_count", 32'(pv_cnt - pv0), 32'd0);

    // Reset in the high part of bit 10, remaining bits follow without a gap
    send_bits(24'h5A5A5A, 9);
    din = 1'b1; wait_cyc(10);
    rst_n = 1'b0; wait_cyc(3);
    rst_n = 1'b1; wait_cyc(13);
    din = 1'b0; wait_cyc(T_BIT - T0H);
    send_bits(24'h5A5A5A, 14);
    gap();
    check("abort_count", 32'(pv_cnt - pv0), 32'd0);
    check("abort_fe", 32'(fe_cnt - fe0), 32'd0);
    check("abort_errs", 32'({err_bit, err_partial}), 32'h0);
    send_bits(24'h654321, 24);
    gap();
    check("resync_count", 32'(pv_cnt - pv0), 32'd1);
    check("resync_data", 32'(pv_data[pv0 % 32]), 32'h654321);
    check("resync_fe", 32'(fe_cnt - fe0), 32'd1);

    // Pass-through: own pixel A, forward B two cycles late
    passthru_en = 1'b1;
    wait_cyc(2);
    pv0 = pv_cnt; fe0 = fe_cnt; mis0 = dout_mis; rise0 = dout_rises;
    send_bits(24'hAA55CC, 24);
    dout_mode = 1'b1;
    send_bits(24'h0F0F0F, 24);
    gap();
    dout_mode = 1'b0;
    wait_cyc(20);
    check("pt_count", 32'(pv_cnt - pv0), 32'd1);
    check("pt_data", 32'(pv_data[pv0 % 32]), 32'hAA55CC);
    check("pt_index", 32'(pv_idx[pv0 % 32]), 32'd0);
    check("pt_dout_match", 32'(dout_mis - mis0), 32'd0);
    check("pt_dout_pulses", 32'(dout_rises - rise0), 32'd24);
    check("pt_fe", 32'(fe_cnt - fe0), 32'd1);
    check("pt_dout_after", 32'(dout), 32'h0);
    passthru_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
